// File: rtl/noise_scheduler_pkg.sv
// ============================================================================
//  Module      : noise_scheduler_pkg
//  Description : Shared FSM encoding, default widths and LFSR feedback helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noise_scheduler_pkg;

    localparam int LFSR_WIDTH     = 16;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_WORD_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] DEF_SEED = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // XNOR of taps 16,15,13,4; the all-zero state is therefore legal.
    function automatic logic lfsr_feedback(input logic [LFSR_WIDTH-1:0] s);
        return ~(s[15] ^ s[14] ^ s[12] ^ s[3]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/noise_scheduler_lfsr.sv
// ============================================================================
//  Module      : noise_scheduler_lfsr
//  Description : 16-bit Fibonacci XNOR LFSR; q is the bit entering the register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noise_scheduler_lfsr
    import noise_scheduler_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic clock,
    input  logic reset_l,
    input  logic en,
    output logic q
);

    logic [LFSR_WIDTH-1:0] lfsr_q;

    assign q = lfsr_feedback(lfsr_q);

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            lfsr_q <= RESET_VAL;
        end else if (en) begin
            lfsr_q <= {lfsr_q[LFSR_WIDTH-2:0], q};
        end
    end

endmodule

`default_nettype wire

// File: rtl/noise_scheduler.sv
// ============================================================================
//  Module      : noise_scheduler
//  Description : Round-robin arbiter serialising requesters onto one LFSR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noise_scheduler
    import noise_scheduler_pkg::*;
#(
    parameter int                    NUM_REQ    = DEF_NUM_REQ,
    parameter int                    WORD_WIDTH = DEF_WORD_WIDTH,
    parameter logic [LFSR_WIDTH-1:0] SEED       = DEF_SEED
) (
    input  logic                       clock,
    input  logic                       reset_l,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         ack,
    output logic [WORD_WIDTH-1:0]      data,
    output logic [$clog2(NUM_REQ)-1:0] data_id,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(WORD_WIDTH);

    state_t                state_q, state_d;
    logic                  busy_q;
    logic [ID_W-1:0]       grant_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WORD_WIDTH-2:0] word_q;
    logic [WORD_WIDTH-1:0] data_q;
    logic [ID_W-1:0]       data_id_q;
    logic [NUM_REQ-1:0]    ack_q;

    logic                  arb_valid;
    logic [ID_W-1:0]       arb_idx;
    logic [ID_W-1:0]       arb_cand;
    int                    arb_pos;
    logic                  shift_last;
    logic                  lfsr_en;
    logic                  lfsr_bit;
    logic                  grant_now;
    logic                  done_entry;
    logic [WORD_WIDTH-1:0] word_next;
    logic [NUM_REQ-1:0]    ack_d;

    noise_scheduler_lfsr #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset_l (reset_l),
        .en      (lfsr_en),
        .q       (lfsr_bit)
    );

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        arb_pos   = 0;
        arb_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_pos  = (int'(grant_q) + 1 + i) % NUM_REQ;
            arb_cand = ID_W'(arb_pos);
            if (!arb_valid && req[arb_cand]) begin
                arb_valid = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    assign shift_last = (cnt_q == CNT_W'(WORD_WIDTH - 1));

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid)  state_d = SHIFT;
            SHIFT:   if (shift_last) state_d = DONE;
            DONE:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_en    = (state_q == SHIFT);
        grant_now  = (state_q == IDLE) && arb_valid;
        done_entry = (state_q == SHIFT) && shift_last;
        word_next  = {word_q, lfsr_bit};
        ack_d      = (state_q == DONE) ? (NUM_REQ'(1) << grant_q) : '0;
    end

    // data/data_id load as the word completes and hold until the next completion.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            grant_q   <= ID_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            word_q    <= '0;
            data_q    <= '0;
            data_id_q <= '0;
            ack_q     <= '0;
        end else begin
            ack_q <= ack_d;
            if (grant_now) begin
                grant_q <= arb_idx;
                cnt_q   <= '0;
            end else if (lfsr_en) begin
                cnt_q  <= shift_last ? '0 : cnt_q + CNT_W'(1);
                word_q <= word_next[WORD_WIDTH-2:0];
            end
            if (done_entry) begin
                data_q    <= word_next;
                data_id_q <= grant_q;
            end
        end
    end

    assign ack     = ack_q;
    assign data    = data_q;
    assign data_id = data_id_q;
    assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_noise_scheduler.sv
// ============================================================================
//  Module      : tb_noise_scheduler
//  Description : Directed self-checking bench for noise_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noise_scheduler;

    logic        clock = 1'b0;
    logic        reset_l;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [15:0] data;
    logic [1:0]  data_id;
    logic        busy;

    int ntests = 0;
    int nfail  = 0;

    // Golden history: every bit the LFSR has produced since reset, oldest first.
    bit hist[$];

    always #5 clock = ~clock;

    noise_scheduler #(
        .NUM_REQ    (4),
        .WORD_WIDTH (16),
        .SEED       (16'h0000)
    ) dut (
        .clock   (clock),
        .reset_l (reset_l),
        .req     (req),
        .ack     (ack),
        .data    (data),
        .data_id (data_id),
        .busy    (busy)
    );

    function automatic bit hb(input int j);
        if (j <= 0) return 1'b0;
        return hist[j-1];
    endfunction

    // Bit n+1 = XNOR of bits produced 16,15,13 and 4 steps earlier.
    task automatic gold_word(output logic [15:0] w);
        int n;
        bit b;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            n = hist.size();
            b = ~(hb(n-15) ^ hb(n-14) ^ hb(n-12) ^ hb(n-3));
            hist.push_back(b);
            w = {w[14:0], b};
        end
    endtask

    task automatic apply_reset();
        reset_l = 1'b0;
        req     = 4'b0000;
        repeat (2) @(posedge clock);
        #1 reset_l = 1'b1;
        hist.delete();
    endtask

    task automatic wait_ack(input int budget, output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(posedge clock);
            #1;
            cyc++;
            if (ack !== 4'b0000) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        req     = 4'b0000;
        #12;
        ntests++; if (ack !== 4'b0000) begin nfail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        ntests++; if (data !== 16'h0000) begin nfail++; $display("FAIL reset_data: got %h expected 0000", data); end
        ntests++; if (data_id !== 2'd0) begin nfail++; $display("FAIL reset_id: got %0d expected 0", data_id); end
        ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clock);
        #1 reset_l = 1'b1;
        hist.delete();
    endtask

    task automatic test_single();
        logic [15:0] gw;
        int cyc;
        bit got;
        gold_word(gw);
        req = 4'b0001;
        wait_ack(40, cyc, got);
        ntests++; if (got !== 1'b1) begin nfail++; $display("FAIL single_timeout: got no ack expected ack"); end
        ntests++; if (cyc !== 18) begin nfail++; $display("FAIL single_latency: got %0d expected 18", cyc); end
        ntests++; if (ack !== 4'b0001) begin nfail++; $display("FAIL single_ack: got %b expected 0001", ack); end
        ntests++; if (data_id !== 2'd0) begin nfail++; $display("FAIL single_id: got %0d expected 0", data_id); end
        ntests++; if (data[15:8] !== 8'hF0) begin nfail++; $display("FAIL single_upper: got %h expected f0", data[15:8]); end
        ntests++; if (data !== gw) begin nfail++; $display("FAIL single_word: got %h expected %h", data, gw); end
        req = 4'b0000;
        @(posedge clock);
        #1;
        ntests++; if (ack !== 4'b0000) begin nfail++; $display("FAIL single_ack_width: got %b expected 0000", ack); end
    endtask

    task automatic test_contention();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        logic [15:0] gw;
        logic [3:0]  ea;
        int cyc;
        bit got;
        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            gold_word(gw);
            ea = 4'b0001 << exp_id[k];
            wait_ack(40, cyc, got);
            ntests++; if (got !== 1'b1) begin nfail++; $display("FAIL contend_timeout[%0d]: got no ack expected ack", k); end
            ntests++; if (cyc !== 18) begin nfail++; $display("FAIL contend_spacing[%0d]: got %0d expected 18", k, cyc); end
            ntests++; if (ack !== ea) begin nfail++; $display("FAIL contend_ack[%0d]: got %b expected %b", k, ack, ea); end
            ntests++; if (int'(data_id) !== exp_id[k]) begin nfail++; $display("FAIL contend_id[%0d]: got %0d expected %0d", k, data_id, exp_id[k]); end
            ntests++; if (data !== gw) begin nfail++; $display("FAIL contend_word[%0d]: got %h expected %h", k, data, gw); end
        end
        req = 4'b0000;
    endtask

    task automatic test_drop();
        logic [15:0] gw;
        int cyc;
        bit got;
        int extra;
        gold_word(gw);
        req = 4'b0100;
        @(posedge clock);
        #1 req = 4'b0000;
        wait_ack(40, cyc, got);
        ntests++; if (got !== 1'b1) begin nfail++; $display("FAIL drop_timeout: got no ack expected ack"); end
        ntests++; if (cyc !== 17) begin nfail++; $display("FAIL drop_latency: got %0d expected 17", cyc); end
        ntests++; if (ack !== 4'b0100) begin nfail++; $display("FAIL drop_ack: got %b expected 0100", ack); end
        ntests++; if (data_id !== 2'd2) begin nfail++; $display("FAIL drop_id: got %0d expected 2", data_id); end
        ntests++; if (data !== gw) begin nfail++; $display("FAIL drop_word: got %h expected %h", data, gw); end
        extra = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (ack !== 4'b0000) extra++;
        end
        ntests++; if (extra !== 0) begin nfail++; $display("FAIL drop_extra_ack: got %0d expected 0", extra); end
        // The following word proves the LFSR moved exactly one word's worth.
        gold_word(gw);
        req = 4'b0001;
        wait_ack(40, cyc, got);
        req = 4'b0000;
        ntests++; if (got !== 1'b1) begin nfail++; $display("FAIL drop_next_timeout: got no ack expected ack"); end
        ntests++; if (data !== gw) begin nfail++; $display("FAIL drop_next_word: got %h expected %h", data, gw); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] gw;
        int cyc;
        bit got;
        int stray;
        req = 4'b0010;
        @(posedge clock);
        repeat (7) @(posedge clock);
        #1;
        ntests++; if (busy !== 1'b1) begin nfail++; $display("FAIL rmid_busy_pre: got %b expected 1", busy); end
        #2 reset_l = 1'b0;
        req = 4'b0000;
        #1;
        ntests++; if (ack !== 4'b0000) begin nfail++; $display("FAIL rmid_ack: got %b expected 0000", ack); end
        ntests++; if (data !== 16'h0000) begin nfail++; $display("FAIL rmid_data: got %h expected 0000", data); end
        ntests++; if (data_id !== 2'd0) begin nfail++; $display("FAIL rmid_id: got %0d expected 0", data_id); end
        ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        repeat (2) @(posedge clock);
        #1 reset_l = 1'b1;
        hist.delete();
        stray = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (ack !== 4'b0000 || busy !== 1'b0) stray++;
        end
        ntests++; if (stray !== 0) begin nfail++; $display("FAIL rmid_stray: got %0d expected 0", stray); end
        gold_word(gw);
        req = 4'b0010;
        wait_ack(40, cyc, got);
        req = 4'b0000;
        ntests++; if (got !== 1'b1) begin nfail++; $display("FAIL rmid_timeout: got no ack expected ack"); end
        ntests++; if (ack !== 4'b0010) begin nfail++; $display("FAIL rmid_new_ack: got %b expected 0010", ack); end
        ntests++; if (data_id !== 2'd1) begin nfail++; $display("FAIL rmid_new_id: got %0d expected 1", data_id); end
        ntests++; if (data[15:8] !== 8'hF0) begin nfail++; $display("FAIL rmid_upper: got %h expected f0", data[15:8]); end
        ntests++; if (data !== gw) begin nfail++; $display("FAIL rmid_word: got %h expected %h", data, gw); end
    endtask

    task automatic test_idle_hold();
        logic [15:0] gw;
        int cyc;
        bit got;
        int bad;
        apply_reset();
        bad = 0;
        repeat (100) begin
            @(posedge clock);
            #1;
            if (busy !== 1'b0 || ack !== 4'b0000) bad++;
        end
        ntests++; if (bad !== 0) begin nfail++; $display("FAIL idle_activity: got %0d expected 0", bad); end
        gold_word(gw);
        req = 4'b0001;
        wait_ack(40, cyc, got);
        req = 4'b0000;
        ntests++; if (got !== 1'b1) begin nfail++; $display("FAIL idle_timeout: got no ack expected ack"); end
        ntests++; if (cyc !== 18) begin nfail++; $display("FAIL idle_latency: got %0d expected 18", cyc); end
        ntests++; if (data !== gw) begin nfail++; $display("FAIL idle_word: got %h expected %h", data, gw); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_drop();
        test_reset_mid();
        test_idle_hold();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/noise_scheduler.md
NOISE_SCHEDULER -- requirements
Module: noise_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NUM_REQ, 4, number of requesters; WORD_WIDTH, 16, random word width in bits; SEED, 16'b0, LFSR reset state.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clock  input  1  rising-edge clock.
- reset_l  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request per requester, held until acked.
- ack  output  NUM_REQ  one-cycle one-hot grant-complete pulse.
- data  output  WORD_WIDTH  assembled random word.
- data_id  output  $clog2(NUM_REQ)  index of the requester that owns data.
- busy  output  1  high whenever state is not IDLE.

Function
REQ-004 The block SHALL serialise all requesters onto one shared LFSR: one bit per enabled cycle, feedback XNOR of taps 16,15,13,4.
REQ-005 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-006 IDLE->SHIFT: taken when any req bit is high at a rising edge; a winner SHALL be latched at that edge.
REQ-007 SHIFT->DONE: taken after exactly WORD_WIDTH SHIFT cycles.
REQ-008 DONE->IDLE: taken unconditionally after one cycle.
REQ-009 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ, and the first set req bit wins.
REQ-010 LFSR enable SHALL be high only in SHIFT, so the LFSR advances exactly WORD_WIDTH steps per grant.
REQ-011 Each SHIFT cycle SHALL shift the LFSR output bit into the word register MSB-first: word <= {word[WORD_WIDTH-2:0], q}.
REQ-012 A shift counter SHALL run 0..WORD_WIDTH-1; SHIFT SHALL exit when the counter equals WORD_WIDTH-1, and the counter SHALL clear on entry to SHIFT.
REQ-013 In DONE, ack[winner] SHALL be high for exactly one cycle and all other ack bits SHALL be low.
REQ-014 In DONE, data SHALL equal the completed word and data_id SHALL equal the winner index.
REQ-015 data and data_id SHALL hold their values until the next DONE.
REQ-016 Latency: with req sampled at edge k in IDLE, ack SHALL be high during the cycle after edge k+WORD_WIDTH+1; throughput SHALL be one word per WORD_WIDTH+2 cycles.
REQ-017 If the winner drops req during SHIFT, the word SHALL still complete and the ack SHALL still be issued, with no abort.
REQ-018 A req bit that is high during DONE SHALL NOT be granted before the next IDLE cycle.
REQ-019 Requests arriving during SHIFT or DONE SHALL wait without loss; req is level-sensitive and nothing is queued.
REQ-020 If req is all-zero in IDLE, the FSM SHALL stay in IDLE and the LFSR SHALL hold.
REQ-021 busy SHALL equal (state != IDLE), registered together with state.

Reset
REQ-022 Asserting reset_l low SHALL, asynchronously and at any time including mid-SHIFT, force state=IDLE, ack=0, data=0, data_id=0, busy=0, counter=0 and LFSR state=SEED.
REQ-023 Reset SHALL set last_grant=NUM_REQ-1 so that requester 0 wins the first tie.
REQ-024 A partially assembled word SHALL be discarded on reset and never acked.

Structure
REQ-025 The state enum and default widths SHALL live in the shared dispatcher package.
REQ-026 The block SHALL instantiate the existing LFSR as its single sub-module, with RESET_VAL=SEED, clock/reset_l shared, and en driven by the FSM.
REQ-027 Arbiter, counter and word register SHALL be local to noise_scheduler.

Verification
REQ-028 Single request: SEED=0, WORD_WIDTH=16, req=4'b0001 held; ack[0] pulses 18 cycles after the sampling edge, data[15:8]=8'hF0, data_id=0, and the full word SHALL match a golden LFSR model.
REQ-029 Contention: req=4'b1111 held; acks arrive in order 0,1,2,3,0, each 18 cycles apart, and each word equals the next 16 golden-model bits.
REQ-030 Drop mid-SHIFT: req[2] pulses for 1 cycle only; ack[2] still pulses once and the LFSR advances exactly 16 steps.
REQ-031 Reset mid-SHIFT: reset_l is asserted on SHIFT cycle 7; no ack is issued and all outputs are 0. A new req[1] after release yields the same word as the REQ-028 first word (0xF0 upper byte).
REQ-032 Idle hold: req=0 for 100 cycles; the LFSR does not advance, busy=0 and ack=0 throughout, and the next word equals the golden model's first word.
